db9md_pad_scanner: RTL and testbench

- Sequential scanner for two Sega Mega Drive 3/6-button pads on the shared SNAC DB9 user-port pins.
- Drives the pad select line (joy_mdsel) and the port multiplexer (joy_split), then samples the 6 active-low data pins.
- Produces two active-high 16-bit button words. These feed the top level's DB9 → joy1a/joy2a remap and the coin/start/fire logic.
- Sits directly upstream of the joystick mapping in the arcade top.

---
 rtl/db9md_pad_scanner.sv | 134 +++++++++++++
 tb/tb_db9md_pad_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/db9md_pad_scanner.sv
// db9md_pad_scanner: two-pad Mega Drive 3/6-button scanner on shared DB9 pins; define DB9MD_DEGLITCH_EN for two-frame agreement commit
module db9md_pad_scanner #(
    parameter int STEP_CYCLES = 480,
    parameter int IDLE_STEPS  = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  pad_6btn,
    output logic        frame_stb
);
    localparam int DW = $clog2(STEP_CYCLES);
    localparam int IW = $clog2(IDLE_STEPS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_STEPS);

    typedef enum logic [1:0] {IDLE, SWITCH, SCAN} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [IW-1:0] idle_cnt;
    logic [2:0]    phase;
    logic          pad;
    logic          commit;
    logic          commit_pad;
    logic          present;
    logic          six;
    logic [11:0]   cap;
    logic [5:0]    pressed;
    logic [13:0]   fresh;
    logic          accept;

    assign pressed = ~joy_in;
    assign fresh   = {present, present & six, present ? cap : 12'h000};

`ifdef DB9MD_DEGLITCH_EN
    logic [13:0] cand [2];
    assign accept = (fresh == cand[commit_pad]);
`else
    assign accept = 1'b1;
`endif

    // step divider, select sequencing, settled-pin capture and atomic per-pad commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            idle_cnt   <= IDLE_LOAD;
            phase      <= '0;
            pad        <= 1'b0;
            commit     <= 1'b0;
            commit_pad <= 1'b0;
            present    <= 1'b0;
            six        <= 1'b0;
            cap        <= '0;
            joy_mdsel  <= 1'b1;
            joy_split  <= 1'b0;
            joystick1  <= '0;
            joystick2  <= '0;
            pad_6btn   <= '0;
            frame_stb  <= 1'b0;
`ifdef DB9MD_DEGLITCH_EN
            cand[0]    <= '0;
            cand[1]    <= '0;
`endif
        end else begin
            div       <= (div == DIV_LAST) ? '0 : div + DW'(1);
            commit    <= 1'b0;
            frame_stb <= commit & commit_pad;
            if (div == '0) begin
                joy_mdsel <= (state != SCAN) | ~phase[0];
                if (state == SWITCH) joy_split <= pad;
            end
            if (div == DIV_LAST) begin
                case (state)
                    IDLE: begin
                        if (idle_cnt == IW'(1)) begin
                            state <= SWITCH;
                            pad   <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt - IW'(1);
                        end
                    end
                    SWITCH: begin
                        state <= SCAN;
                        phase <= '0;
                    end
                    default: begin
                        phase <= phase + 3'd1;
                        case (phase)
                            3'd0: cap[5:0] <= {pressed[5], pressed[4], pressed[0], pressed[1], pressed[2], pressed[3]};
                            3'd1: begin
                                present  <= (joy_in[3:2] == 2'b00);
                                cap[7:6] <= pressed[5:4];
                            end
                            3'd5: six <= (joy_in[3:0] == 4'b0000);
                            3'd6: cap[11:8] <= six ? {pressed[0], pressed[1], pressed[2], pressed[3]} : 4'h0;
                            3'd7: begin
                                commit     <= 1'b1;
                                commit_pad <= pad;
                                if (pad) begin
                                    state    <= IDLE;
                                    idle_cnt <= IDLE_LOAD;
                                end else begin
                                    state <= SWITCH;
                                    pad   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
            if (commit) begin
                if (accept) begin
                    if (commit_pad) begin
                        joystick2   <= {4'h0, fresh[11:0]};
                        pad_6btn[1] <= fresh[12];
                    end else begin
                        joystick1   <= {4'h0, fresh[11:0]};
                        pad_6btn[0] <= fresh[12];
                    end
                end
`ifdef DB9MD_DEGLITCH_EN
                cand[commit_pad] <= fresh;
`endif
            end
        end
    end
endmodule

// File: tb/tb_db9md_pad_scanner.sv
// tb_db9md_pad_scanner: directed scan of pad models with a per-frame expected-result queue
module tb_db9md_pad_scanner;
    localparam int STEP = 4;
    localparam int IDLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  pad_6btn;
    logic        frame_stb;

    db9md_pad_scanner #(.STEP_CYCLES(STEP), .IDLE_STEPS(IDLE)) dut (
        .clk(clk),
        .reset(reset),
        .joy_in(joy_in),
        .joy_mdsel(joy_mdsel),
        .joy_split(joy_split),
        .joystick1(joystick1),
        .joystick2(joystick2),
        .pad_6btn(pad_6btn),
        .frame_stb(frame_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [1:0]  six;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          lows;
    logic        pm;
    logic        ps;
    int          ptype [2];
    logic [11:0] pbtn [2];
    logic        glitch;
    logic [13:0] mc [2];
    logic [13:0] mo [2];

    // edges since reset released: before edge k, cyc == k
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // pad-side count of select falling edges since the port was selected
    always @(negedge clk) begin
        if (reset) begin
            lows <= 0;
            pm   <= 1'b1;
            ps   <= 1'b0;
        end else begin
            if (joy_split != ps) lows <= 0;
            else if (pm && !joy_mdsel) lows <= lows + 1;
            pm <= joy_mdsel;
            ps <= joy_split;
        end
    end

    function automatic logic [5:0] pins(int t, logic [11:0] b, logic m, int n);
        if (t == 0) return 6'h3F;
        if (m) begin
            if (t == 2 && n == 3) return ~{b[5], b[4], b[8], b[9], b[10], b[11]};
            return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
        end
        if (t == 2 && n >= 4) return {~b[7], ~b[6], 4'b1111};
        if (t == 2 && n == 3) return {~b[7], ~b[6], 4'b0000};
        return {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
    endfunction

    // pins are scrambled on every non-sample clock while glitch is on
    always_comb begin
        joy_in = pins(ptype[joy_split], pbtn[joy_split], joy_mdsel, lows);
        if (glitch && (cyc % 4) != 3) joy_in = 6'h00;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] cand_of(int p);
        logic [11:0] w;
        w = (ptype[p] == 2) ? pbtn[p] : (pbtn[p] & 12'h0FF);
        return (ptype[p] == 0) ? 14'h0 : {1'b1, ptype[p] == 2, w};
    endfunction

    task automatic push_frame(int at);
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            logic [13:0] c;
            c = cand_of(p);
`ifdef DB9MD_DEGLITCH_EN
            if (c == mc[p]) mo[p] = c;
`else
            mo[p] = c;
`endif
            mc[p] = c;
        end
        e.j1  = {4'h0, mo[0][11:0]};
        e.j2  = {4'h0, mo[1][11:0]};
        e.six = {mo[1][12], mo[0][12]};
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic wait_cyc(int n);
        int k;
        k = 0;
        while (cyc != n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) check("wait_timeout", cyc, n);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_j1"}, joystick1, 0);
        check({tag, "_j2"}, joystick2, 0);
        check({tag, "_6btn"}, pad_6btn, 0);
        check({tag, "_stb"}, frame_stb, 0);
        check({tag, "_mdsel"}, joy_mdsel, 1);
        check({tag, "_split"}, joy_split, 0);
    endtask

    // scoreboard: each frame strobe pops the expected committed state
    always @(negedge clk) begin
        if (!reset && frame_stb) begin
            check("stb_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("stb_cycle", cyc - 1, e.at);
                check("frame_j1", joystick1, e.j1);
                check("frame_j2", joystick2, e.j2);
                check("frame_6btn", pad_6btn, e.six);
            end
        end
    end

    initial begin
        logic [15:0] old1;
        logic [15:0] old2;
        ptype[0] = 0; ptype[1] = 0;
        pbtn[0] = '0; pbtn[1] = '0;
        mc[0] = '0; mc[1] = '0;
        mo[0] = '0; mo[1] = '0;
        glitch = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        push_frame(88);
        reset = 1'b0;
        wait_cyc(17);
        check("sw0_split", joy_split, 0);
        check("sw0_mdsel", joy_mdsel, 1);
        wait_cyc(25);
        check("p0ph1_mdsel", joy_mdsel, 0);
        wait_cyc(29);
        check("p0ph2_mdsel", joy_mdsel, 1);
        wait_cyc(49);
        check("p0ph7_mdsel", joy_mdsel, 0);
        wait_cyc(53);
        check("sw1_split", joy_split, 1);
        check("sw1_mdsel", joy_mdsel, 1);
        wait_cyc(61);
        check("p1ph1_mdsel", joy_mdsel, 0);
        wait_cyc(89);
        check("idle_mdsel", joy_mdsel, 1);
        wait_cyc(90);
        push_frame(176);
        wait_cyc(178);
        ptype[0] = 1; pbtn[0] = 12'h048;
        ptype[1] = 2; pbtn[1] = 12'h990;
        old1 = joystick1;
        old2 = joystick2;
        push_frame(264);
        wait_cyc(228);
        check("j1_before_commit", joystick1, old1);
        wait_cyc(229);
        check("j1_at_commit", joystick1, {4'h0, mo[0][11:0]});
        check("j2_held", joystick2, old2);
        wait_cyc(266);
        push_frame(352);
        wait_cyc(354);
        glitch = 1'b1;
        push_frame(440);
        wait_cyc(442);
        glitch = 1'b0;
        pbtn[0] = 12'h0C8;
        push_frame(528);
        wait_cyc(530);
        pbtn[0] = 12'h048;
        push_frame(616);
        wait_cyc(618);
        pbtn[0] = 12'h0C8;
        push_frame(704);
        wait_cyc(706);
        push_frame(792);
        wait_cyc(794);
        pbtn[0] = 12'h048;
        push_frame(880);
        wait_cyc(882);
        push_frame(968);
        wait_cyc(1049);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midrst");
        mc[0] = '0; mc[1] = '0;
        mo[0] = '0; mo[1] = '0;
        push_frame(88);
        wait_cyc(52);
        check("rescan_j1_before", joystick1, 0);
        wait_cyc(53);
        check("rescan_j1", joystick1, {4'h0, mo[0][11:0]});
        wait_cyc(90);
        push_frame(176);
        wait_cyc(178);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
